// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: segment bit positions, override patterns
// and the pattern type used between the lookup ROM and the output stage.
package seg7_pkg;

  localparam int SEG_A = 6;
  localparam int SEG_B = 5;
  localparam int SEG_C = 4;
  localparam int SEG_D = 3;
  localparam int SEG_E = 2;
  localparam int SEG_F = 1;
  localparam int SEG_G = 0;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_ALL_ON  = 7'h7F;
  localparam seg_t SEG_ALL_OFF = 7'h00;

endpackage

// File: rtl/seg7_rom.sv
// Combinational 3-bit code to active-high a..g segment pattern lookup.
module seg7_rom
  import seg7_pkg::*;
(
  input  logic [2:0] code,
  output seg_t       pattern
);

  always_comb begin
    pattern = SEG_ALL_OFF;
    case (code)
      3'd0: pattern = 7'b1111110;
      3'd1: pattern = 7'b0110000;
      3'd2: pattern = 7'b1101101;
      3'd3: pattern = 7'b1111001;
      3'd4: pattern = 7'b0110011;
      3'd5: pattern = 7'b1011011;
      3'd6: pattern = 7'b1011111;
      3'd7: pattern = 7'b1110000;
      default: pattern = SEG_ALL_OFF;
    endcase
  end

endmodule

// File: rtl/conditional_decoder_seg7.sv
// Registered seven-segment decoder with lamp-test/blank overrides and
// selectable output polarity; F comes straight from a flop.
module conditional_decoder_seg7
  import seg7_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] ABC,
  input  logic       lamp_test,
  input  logic       blank,
  output logic [6:0] F
);

  seg_t rom_pattern;
  seg_t pattern_next;
  seg_t drive_next;
  seg_t off_drive;
  seg_t f_reg;

  seg7_rom u_rom (
    .code    (ABC),
    .pattern (rom_pattern)
  );

  // Lamp test outranks blanking so a panel check works even on a blanked digit.
  always_comb begin
    pattern_next = rom_pattern;
    if (lamp_test) begin
      pattern_next = SEG_ALL_ON;
    end else if (blank) begin
      pattern_next = SEG_ALL_OFF;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 7; gi++) begin : g_polarity
      assign drive_next[gi] = pattern_next[gi] ^ ACTIVE_LOW;
      assign off_drive[gi]  = SEG_ALL_OFF[gi] ^ ACTIVE_LOW;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      f_reg <= off_drive;
    end else begin
      f_reg <= drive_next;
    end
  end

  assign F = f_reg;

endmodule

// File: tb/tb_conditional_decoder_seg7.sv
// Self-checking bench: both polarities side by side against a segment-letter
// model of the digits.
module tb_conditional_decoder_seg7;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] ABC = 3'd0;
  logic       lamp_test = 1'b0;
  logic       blank = 1'b0;
  logic [6:0] f_h;
  logic [6:0] f_l;

  int n_cmp = 0;
  int n_err = 0;

  // Which segment letters light for each digit shape.
  string shapes [0:7] = '{"abcdef", "bc", "abdeg", "abcdg",
                          "bcfg", "acdfg", "acdefg", "abc"};

  always #5 clk = ~clk;

  conditional_decoder_seg7 #(.ACTIVE_LOW(1'b0)) dut_h (
    .clk(clk), .rst_n(rst_n), .ABC(ABC), .lamp_test(lamp_test), .blank(blank), .F(f_h)
  );

  conditional_decoder_seg7 #(.ACTIVE_LOW(1'b1)) dut_l (
    .clk(clk), .rst_n(rst_n), .ABC(ABC), .lamp_test(lamp_test), .blank(blank), .F(f_l)
  );

  function automatic logic [6:0] model(bit rst, logic [2:0] abc, bit lt, bit bl, bit al);
    logic [6:0] lit;
    string s;
    int idx;
    lit = 7'd0;
    if (rst) begin
      lit = 7'd0;
    end else if (lt) begin
      lit = 7'h7F;
    end else if (bl) begin
      lit = 7'd0;
    end else begin
      s = shapes[abc];
      for (int i = 0; i < s.len(); i++) begin
        idx = int'(s[i]) - 97;
        lit[6 - idx] = 1'b1;
      end
    end
    return al ? ~lit : lit;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ABC = 3'b101; lamp_test = 1'b1; blank = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_cmp++;
      if (f_h !== 7'b0000000) begin
        n_err++; $display("FAIL reset_h cyc=%0d got=%b want=%b", c, f_h, 7'b0000000);
      end
      n_cmp++;
      if (f_l !== 7'b1111111) begin
        n_err++; $display("FAIL reset_l cyc=%0d got=%b want=%b", c, f_l, 7'b1111111);
      end
      $display("reset cyc=%0d F_h=%b F_l=%b", c, f_h, f_l);
    end
    rst_n = 1'b1; lamp_test = 1'b0;
  endtask

  task automatic test_sweep();
    logic [6:0] exp;
    lamp_test = 1'b0; blank = 1'b0;
    for (int v = 0; v < 8; v++) begin
      ABC = 3'(v);
      tick();
      exp = model(1'b0, 3'(v), 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (f_h !== exp) begin
        n_err++; $display("FAIL sweep ABC=%0d got=%b want=%b", v, f_h, exp);
      end
      if (v == 2) begin
        n_cmp++;
        if (f_h !== 7'b1101101) begin
          n_err++; $display("FAIL sweep_two got=%b want=%b", f_h, 7'b1101101);
        end
      end
      if (v == 7) begin
        n_cmp++;
        if (f_h !== 7'b1110000) begin
          n_err++; $display("FAIL sweep_seven got=%b want=%b", f_h, 7'b1110000);
        end
      end
      $display("sweep ABC=%0d F_h=%b", v, f_h);
    end
  endtask

  task automatic test_overrides();
    ABC = 3'b001; lamp_test = 1'b1; blank = 1'b0;
    tick();
    n_cmp++;
    if (f_h !== 7'b1111111) begin
      n_err++; $display("FAIL lamp_test got=%b want=%b", f_h, 7'b1111111);
    end
    $display("override lamp F_h=%b", f_h);
    lamp_test = 1'b0; blank = 1'b1;
    tick();
    n_cmp++;
    if (f_h !== 7'b0000000) begin
      n_err++; $display("FAIL blank got=%b want=%b", f_h, 7'b0000000);
    end
    $display("override blank F_h=%b", f_h);
    lamp_test = 1'b1; blank = 1'b1;
    tick();
    n_cmp++;
    if (f_h !== 7'b1111111) begin
      n_err++; $display("FAIL both_overrides got=%b want=%b", f_h, 7'b1111111);
    end
    n_cmp++;
    if (f_l !== 7'b0000000) begin
      n_err++; $display("FAIL both_overrides_l got=%b want=%b", f_l, 7'b0000000);
    end
    $display("override both F_h=%b F_l=%b", f_h, f_l);
    lamp_test = 1'b0; blank = 1'b0;
  endtask

  task automatic test_polarity();
    ABC = 3'b000;
    tick();
    n_cmp++;
    if (f_l !== 7'b0000001) begin
      n_err++; $display("FAIL polarity_zero got=%b want=%b", f_l, 7'b0000001);
    end
    n_cmp++;
    if (f_h !== 7'b1111110) begin
      n_err++; $display("FAIL polarity_zero_h got=%b want=%b", f_h, 7'b1111110);
    end
    $display("polarity ABC=0 F_h=%b F_l=%b", f_h, f_l);
  endtask

  task automatic test_midcycle();
    ABC = 3'b011;
    tick();
    n_cmp++;
    if (f_h !== 7'b1111001) begin
      n_err++; $display("FAIL mid_before got=%b want=%b", f_h, 7'b1111001);
    end
    #2 ABC = 3'b100;
    #1;
    n_cmp++;
    if (f_h !== 7'b1111001) begin
      n_err++; $display("FAIL mid_hold got=%b want=%b", f_h, 7'b1111001);
    end
    tick();
    n_cmp++;
    if (f_h !== 7'b0110011) begin
      n_err++; $display("FAIL mid_after got=%b want=%b", f_h, 7'b0110011);
    end
    $display("midcycle 3->4 F_h=%b", f_h);
  endtask

  task automatic test_reset_release();
    rst_n = 1'b0; ABC = 3'b110;
    tick();
    n_cmp++;
    if (f_h !== 7'b0000000) begin
      n_err++; $display("FAIL release_in_reset got=%b want=%b", f_h, 7'b0000000);
    end
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (f_h !== 7'b1011111) begin
      n_err++; $display("FAIL release_first got=%b want=%b", f_h, 7'b1011111);
    end
    $display("release ABC=6 F_h=%b", f_h);
  endtask

  task automatic test_random();
    logic [6:0] exp_h, exp_l;
    bit r, lt, bl;
    logic [2:0] a;
    for (int n = 0; n < 300; n++) begin
      r  = ($urandom_range(0, 15) == 0);
      lt = ($urandom_range(0, 7) == 0);
      bl = ($urandom_range(0, 5) == 0);
      a  = 3'($urandom_range(0, 7));
      rst_n = ~r; lamp_test = lt; blank = bl; ABC = a;
      tick();
      exp_h = model(r, a, lt, bl, 1'b0);
      exp_l = model(r, a, lt, bl, 1'b1);
      n_cmp++;
      if (f_h !== exp_h) begin
        n_err++; $display("FAIL random_h n=%0d got=%b want=%b", n, f_h, exp_h);
      end
      n_cmp++;
      if (f_l !== exp_l) begin
        n_err++; $display("FAIL random_l n=%0d got=%b want=%b", n, f_l, exp_l);
      end
      $display("random n=%0d rst=%0d lt=%0d bl=%0d ABC=%0d F_h=%b F_l=%b",
               n, r, lt, bl, a, f_h, f_l);
    end
    rst_n = 1'b1; lamp_test = 1'b0; blank = 1'b0;
  endtask

  initial begin
    #1;
    test_reset();
    test_sweep();
    test_overrides();
    test_polarity();
    test_midcycle();
    test_reset_release();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
